// File: rtl/grid_sequencer_if.sv
// Host-side request/response bundle for grid_sequencer.
// The host drives the request and the ready; the sequencer drives busy and the result record.
interface grid_sequencer_if #(
    parameter int LFSR_WIDTH = 8,
    parameter int TRIES_W    = 3,
    parameter int CYC_W      = 24
);
    logic                  req;
    logic [LFSR_WIDTH-1:0] seed_in;
    logic                  busy;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_success;
    logic [TRIES_W-1:0]    rsp_tries;
    logic [LFSR_WIDTH-1:0] rsp_seed;
    logic [CYC_W-1:0]      rsp_cycles;

    modport master (
        output req, seed_in, rsp_ready,
        input  busy, rsp_valid, rsp_success, rsp_tries, rsp_seed, rsp_cycles
    );

    modport slave (
        input  req, seed_in, rsp_ready,
        output busy, rsp_valid, rsp_success, rsp_tries, rsp_seed, rsp_cycles
    );
endinterface

// File: rtl/grid_sequencer.sv
// Run controller for one grid generator: resets, settles, starts and watches the grid,
// retrying with a derived seed until it succeeds or the attempt budget runs out.
module grid_sequencer #(
    parameter int LFSR_WIDTH     = 8,
    parameter int MAX_TRIES      = 4,
    parameter int SEED_STRIDE    = 1,
    parameter int RESET_HOLD     = 2,
    parameter int SETTLE_CYCLES  = 32,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CYC_W          = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    grid_sequencer_if.slave       host,
    output logic                  grid_reset,
    output logic                  grid_start,
    output logic [LFSR_WIDTH-1:0] grid_seed,
    input  logic                  grid_done,
    input  logic                  grid_success
);

    localparam int TRIES_W   = $clog2(MAX_TRIES + 1);
    localparam int PHASE_MAX = (RESET_HOLD > SETTLE_CYCLES) ? RESET_HOLD : SETTLE_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int RUN_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PHASE_W-1:0]    HOLD_LAST   = PHASE_W'(RESET_HOLD - 1);
    localparam logic [PHASE_W-1:0]    SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
    localparam logic [RUN_W-1:0]      RUN_LAST    = RUN_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TRIES_W-1:0]    TRIES_LAST  = TRIES_W'(MAX_TRIES);
    localparam logic [LFSR_WIDTH-1:0] STRIDE      = LFSR_WIDTH'(SEED_STRIDE);
    localparam logic [CYC_W-1:0]      CYC_MAX     = '1;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SETTLE,
        START,
        RUN,
        RESPOND
    } state_t;

    state_t                state;
    logic [PHASE_W-1:0]    phase_cnt;
    logic [RUN_W-1:0]      run_cnt;
    logic [TRIES_W-1:0]    tries;
    logic [LFSR_WIDTH-1:0] seed;
    logic [CYC_W-1:0]      cyc_cnt;

    logic [CYC_W-1:0]      cyc_next;
    logic [LFSR_WIDTH-1:0] seed_first;
    logic [LFSR_WIDTH-1:0] seed_retry;
    logic                  run_end;
    logic                  attempt_ok;

    // The grid's LFSR locks up on an all-zero seed, so zero is always bumped to one.
    function automatic logic [LFSR_WIDTH-1:0] nonzero(input logic [LFSR_WIDTH-1:0] s);
        return (s == '0) ? LFSR_WIDTH'(1) : s;
    endfunction

    assign cyc_next   = (cyc_cnt == CYC_MAX) ? cyc_cnt : cyc_cnt + 1'b1;
    assign seed_first = nonzero(host.seed_in);
    assign seed_retry = nonzero(seed + STRIDE);
    assign run_end    = grid_done || (run_cnt == RUN_LAST);
    assign attempt_ok = grid_done && grid_success;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            phase_cnt        <= '0;
            run_cnt          <= '0;
            tries            <= '0;
            seed             <= '0;
            cyc_cnt          <= '0;
            grid_reset       <= 1'b1;
            grid_start       <= 1'b0;
            grid_seed        <= '0;
            host.busy        <= 1'b0;
            host.rsp_valid   <= 1'b0;
            host.rsp_success <= 1'b0;
            host.rsp_tries   <= '0;
            host.rsp_seed    <= '0;
            host.rsp_cycles  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.req) begin
                        seed       <= seed_first;
                        grid_seed  <= seed_first;
                        tries      <= TRIES_W'(1);
                        cyc_cnt    <= '0;
                        phase_cnt  <= '0;
                        grid_reset <= 1'b1;
                        host.busy  <= 1'b1;
                        state      <= RST;
                    end
                end

                RST: begin
                    cyc_cnt <= cyc_next;
                    if (phase_cnt == HOLD_LAST) begin
                        phase_cnt  <= '0;
                        grid_reset <= 1'b0;
                        state      <= SETTLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                SETTLE: begin
                    cyc_cnt <= cyc_next;
                    if (phase_cnt == SETTLE_LAST) begin
                        phase_cnt  <= '0;
                        grid_start <= 1'b1;
                        state      <= START;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                START: begin
                    cyc_cnt    <= cyc_next;
                    grid_start <= 1'b0;
                    run_cnt    <= '0;
                    state      <= RUN;
                end

                // A done on the timeout cycle wins, since attempt_ok is tested before retrying.
                RUN: begin
                    cyc_cnt <= cyc_next;
                    if (run_end) begin
                        if (attempt_ok || tries == TRIES_LAST) begin
                            host.rsp_valid   <= 1'b1;
                            host.rsp_success <= attempt_ok;
                            host.rsp_tries   <= tries;
                            host.rsp_seed    <= seed;
                            host.rsp_cycles  <= cyc_next;
                            state            <= RESPOND;
                        end else begin
                            seed       <= seed_retry;
                            grid_seed  <= seed_retry;
                            tries      <= tries + 1'b1;
                            phase_cnt  <= '0;
                            grid_reset <= 1'b1;
                            state      <= RST;
                        end
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end

                RESPOND: begin
                    if (host.rsp_ready) begin
                        host.rsp_valid <= 1'b0;
                        host.busy      <= 1'b0;
                        grid_reset     <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
